// File: rtl/dsp_stream_pkg.sv
// Shared types and constants for the DSP stream blocks (framer, data switch).
package dsp_stream_pkg;

  // Frame length in force after reset, in beats.
  localparam int DSP_DEFAULT_LEN = 1024;

  // Default sample bus width used by the switch-side beat record.
  localparam int DSP_DATA_W = 32;

  // Framer state: IDLE means no frame open (beat counter is zero).
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_t;

  // One stream beat as it travels through register slices.
  typedef struct packed {
    logic [DSP_DATA_W-1:0] data;
    logic                  last;
    logic                  user;
  } dsp_beat_t;

endpackage

// File: rtl/dsp_axis_skid_buf.sv
// Two-entry AXI-Stream register slice: a registered output stage plus one
// skid register. Full throughput, registered in_ready, order preserved.
module dsp_axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_q, out_d, sk_q, sk_d;
  logic         out_v_q, out_v_d, sk_v_q, sk_v_d, rdy_q, rdy_d;

  // Next state: drain output, refill it from skid first, then from input.
  always_comb begin
    out_v_d = out_v_q;
    out_d   = out_q;
    sk_v_d  = sk_v_q;
    sk_d    = sk_q;
    if (out_v_q && out_ready) out_v_d = 1'b0;
    if (sk_v_q && !out_v_d) begin
      out_v_d = 1'b1;
      out_d   = sk_q;
      sk_v_d  = 1'b0;
    end
    // rdy_q implies the skid was empty, so the input never overtakes it.
    if (in_valid && rdy_q) begin
      if (!out_v_d) begin
        out_v_d = 1'b1;
        out_d   = in_data;
      end else begin
        sk_v_d = 1'b1;
        sk_d   = in_data;
      end
    end
    rdy_d = !sk_v_d;
  end

  // State registers; ready is held low through the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      out_v_q <= 1'b0;
      sk_q    <= '0;
      sk_v_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      out_v_q <= out_v_d;
      sk_q    <= sk_d;
      sk_v_q  <= sk_v_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = out_q;
  assign out_valid = out_v_q;

endmodule

// File: rtl/dsp_stream_framer.sv
// Cuts a continuous sample stream into frames of programmable length by
// generating m_axis_tlast. The length arrives on its own stream channel and is
// only applied between frames.
// Optional feature macro: DSP_FRAMER_TUSER_EN adds m_axis_tuser, set on the
// first beat of every frame.
module dsp_stream_framer
  import dsp_stream_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int LEN_WIDTH           = 16,
  parameter int DEFAULT_LEN         = DSP_DEFAULT_LEN
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [LEN_WIDTH-1:0]             s_axis_tdata_len,
  input  logic                             s_axis_tvalid_len,
  output logic                             s_axis_tready_len,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0] m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
`ifdef DSP_FRAMER_TUSER_EN
  output logic                             m_axis_tuser,
`endif
  input  logic                             m_axis_tready,
  output logic [LEN_WIDTH-1:0]             frame_len,
  output logic                             len_err
);

  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
`ifdef DSP_FRAMER_TUSER_EN
  localparam int PW = DW + 2;
`else
  localparam int PW = DW + 1;
`endif

  frame_state_t         state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic [LEN_WIDTH-1:0] pend_len_q, pend_len_d;
  logic                 pend_v_q, pend_v_d;
  logic                 len_err_q, len_err_d;

  logic                 beat_acc, len_acc, len_zero, new_len_v, apply, is_last;
  logic [LEN_WIDTH-1:0] new_len, eff_len;
  logic [PW-1:0]        pay_in, pay_out;

  assign s_axis_tready_len = !pend_v_q;
  assign beat_acc          = s_axis_tvalid && s_axis_tready;
  assign len_acc           = s_axis_tvalid_len && s_axis_tready_len;
  assign len_zero          = (s_axis_tdata_len == '0);

  // Length candidate: a held pending value, else a non-zero value arriving
  // now (the channel is blocked while one is pending, so they never clash).
  // It takes effect only between frames, and a first beat in that same cycle
  // already uses it.
  always_comb begin
    new_len_v = pend_v_q || (len_acc && !len_zero);
    new_len   = pend_v_q ? pend_len_q : s_axis_tdata_len;
    apply     = new_len_v && (state_q == ST_IDLE);
    eff_len   = apply ? new_len : frame_len_q;
    is_last   = (cnt_q == eff_len - LEN_WIDTH'(1));
  end

  // Frame counter, FSM and length bookkeeping. Beats are tagged as they are
  // accepted; the slice preserves order, so tags line up at the output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_len_d = frame_len_q;
    pend_len_d  = pend_len_q;
    pend_v_d    = pend_v_q;
    len_err_d   = len_acc && len_zero;
    if (apply) begin
      frame_len_d = new_len;
      pend_v_d    = 1'b0;
    end else if (len_acc && !len_zero) begin
      pend_len_d = s_axis_tdata_len;
      pend_v_d   = 1'b1;
    end
    if (beat_acc) begin
      if (is_last) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q + LEN_WIDTH'(1);
        state_d = ST_FRAME;
      end
    end
  end

  // Control registers; reset abandons any open frame and pending length.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_len_q <= LEN_WIDTH'(DEFAULT_LEN);
      pend_len_q  <= '0;
      pend_v_q    <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_len_q <= frame_len_d;
      pend_len_q  <= pend_len_d;
      pend_v_q    <= pend_v_d;
      len_err_q   <= len_err_d;
    end
  end

`ifdef DSP_FRAMER_TUSER_EN
  assign pay_in = {(cnt_q == '0), is_last, s_axis_tdata};
  assign m_axis_tuser = pay_out[DW+1];
`else
  assign pay_in = {is_last, s_axis_tdata};
`endif

  dsp_axis_skid_buf #(.W(PW)) u_slice (
    .clk       (ACLK),
    .rst       (ARESET),
    .in_data   (pay_in),
    .in_valid  (s_axis_tvalid),
    .in_ready  (s_axis_tready),
    .out_data  (pay_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign m_axis_tdata = pay_out[DW-1:0];
  assign m_axis_tlast = pay_out[DW];
  assign frame_len    = frame_len_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_dsp_stream_framer.sv
// Directed bench for dsp_stream_framer with a scoreboard of expected beats.
module tb_dsp_stream_framer;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [LW-1:0] s_axis_tdata_len = '0;
  logic          s_axis_tvalid_len = 1'b0;
  logic          s_axis_tready_len;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
`ifdef DSP_FRAMER_TUSER_EN
  logic          m_axis_tuser;
`endif
  logic          m_axis_tready = 1'b1;
  logic [LW-1:0] frame_len;
  logic          len_err;

  dsp_stream_framer dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .s_axis_tdata_len  (s_axis_tdata_len),
    .s_axis_tvalid_len (s_axis_tvalid_len),
    .s_axis_tready_len (s_axis_tready_len),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
`ifdef DSP_FRAMER_TUSER_EN
    .m_axis_tuser      (m_axis_tuser),
`endif
    .m_axis_tready     (m_axis_tready),
    .frame_len         (frame_len),
    .len_err           (len_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t    sb[$];
  int      vectors = 0;
  int      errs = 0;
  bit      rnd_ready = 1'b0;

  // Reference frame model: length in force, beat index, pending length.
  int          m_len = 1024;
  int          m_cnt = 0;
  bit          m_pend_v = 1'b0;
  int          m_pend = 0;
  logic [DW-1:0] seq = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: picks tready, checks stall stability and pops the scoreboard.
  exp_t hold_v;
  bit   hold_chk = 1'b0;
  always @(negedge ACLK) begin
    exp_t e;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (ARESET) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        chk("stall_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast}),
            64'({1'b1, hold_v.data, hold_v.last}));
      hold_chk = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("beat", 64'({m_axis_tdata, m_axis_tlast}), 64'({e.data, e.last}));
        end
      end else if (m_axis_tvalid) begin
        hold_chk = 1'b1;
        hold_v   = '{m_axis_tdata, m_axis_tlast};
      end
    end
  end

  // One cycle of stimulus at the falling edge; accept flags are known here
  // because both ready outputs are registered.
  task automatic step(input bit bv, input bit lv, input logic [LW-1:0] lval,
                      output bit acc, output bit lacc);
    @(negedge ACLK);
    s_axis_tvalid     = bv;
    s_axis_tdata      = seq;
    s_axis_tvalid_len = lv;
    s_axis_tdata_len  = lval;
    acc  = 1'b0;
    lacc = lv && s_axis_tready_len;
    if (m_cnt == 0 && m_pend_v) begin
      m_len    = m_pend;
      m_pend_v = 1'b0;
    end
    if (lacc && lval != 0) begin
      if (m_cnt == 0) m_len = int'(lval);
      else begin
        m_pend   = int'(lval);
        m_pend_v = 1'b1;
      end
    end
    if (bv && s_axis_tready) begin
      acc = 1'b1;
      sb.push_back('{seq, (m_cnt == m_len - 1)});
      m_cnt = (m_cnt == m_len - 1) ? 0 : m_cnt + 1;
      seq++;
    end
  endtask

  task automatic send(input int n, output int stalls);
    int got = 0;
    int guard = 0;
    bit a, l;
    stalls = 0;
    while (got < n && guard < n * 20 + 100) begin
      step(1'b1, 1'b0, '0, a, l);
      if (a) got++; else stalls++;
      guard++;
    end
    if (got < n) chk("send_timeout", 64'(got), 64'(n));
    step(1'b0, 1'b0, '0, a, l);
  endtask

  // Returns at the falling edge right after the length handshake.
  task automatic write_len(input logic [LW-1:0] v);
    bit a, l;
    int tries = 0;
    l = 1'b0;
    while (!l && tries < 200) begin
      step(1'b0, 1'b1, v, a, l);
      tries++;
    end
    if (!l) chk("len_timeout", 64'(tries), 64'd0);
    step(1'b0, 1'b0, '0, a, l);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge ACLK);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_len_tready"}, 64'(s_axis_tready_len), 64'd1);
    chk({tag, "_frame_len"}, 64'(frame_len), 64'd1024);
    chk({tag, "_len_err"}, 64'(len_err), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit a, l;

    // Reset values
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    chk_reset("rst");
    ARESET = 1'b0;

    // 1: default length, 3072 beats, no backpressure
    send(3072, stalls);
    chk("t1_stalls", 64'(stalls), 64'd0);
    drain();

    // 2: length 4 written while idle, 12 beats
    write_len(16'd4);
    chk("t2_frame_len", 64'(frame_len), 64'd4);
    send(12, stalls);
    chk("t2_stalls", 64'(stalls), 64'd0);
    drain();

    // 3: length 8 running, length 3 written alongside beat 5
    write_len(16'd8);
    chk("t3_frame_len8", 64'(frame_len), 64'd8);
    send(4, stalls);
    step(1'b1, 1'b1, 16'd3, a, l);
    chk("t3_len_acc", 64'({a, l}), 64'b11);
    step(1'b1, 1'b0, '0, a, l);
    chk("t3_len_blocked", 64'(s_axis_tready_len), 64'd0);
    chk("t3_frame_len_kept", 64'(frame_len), 64'd8);
    send(8, stalls);
    drain();
    chk("t3_frame_len3", 64'(frame_len), 64'd3);

    // 4: random backpressure, length 7, 1001 beats (whole frames)
    write_len(16'd7);
    rnd_ready = 1'b1;
    send(1001, stalls);
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(negedge ACLK);

    // 5: zero length rejected, then length 1
    write_len(16'd0);
    chk("t5_len_err_pulse", 64'(len_err), 64'd1);
    chk("t5_frame_len_kept", 64'(frame_len), 64'd7);
    @(negedge ACLK);
    chk("t5_len_err_clear", 64'(len_err), 64'd0);
    write_len(16'd1);
    chk("t5_frame_len1", 64'(frame_len), 64'd1);
    send(5, stalls);
    drain();

    // 6: reset during beat 3 of a length-5 frame
    write_len(16'd5);
    send(2, stalls);
    @(negedge ACLK);
    ARESET = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge ACLK);
    sb.delete();
    m_len = 1024; m_cnt = 0; m_pend_v = 1'b0;
    chk_reset("t6_rst");
    ARESET = 1'b0;
    s_axis_tvalid = 1'b0;
    send(1024, stalls);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
